handshake_serializer: RTL and testbench
=======================================

Name: handshake_serializer

Overview:
- Parametrised Free/Put parallel-to-serial link stage. Generalises the fixed 32-bit/4-beat producer path.
- Accepts one PW-bit word from upstream over a Put/Free handshake, then emits it as PW/SW beats of SW bits over a downstream Put/Free handshake.
- Adds beyond the fixed version: selectable beat order, per-beat back-pressure (stall mid-word), zero-bubble back-to-back words, synchronous flush.
- Sits between a payload producer and a serial link; pairs with a matching deserializer on the consumer side.

Parameters:
- PW, 32, parallel payload width in bits; must be a multiple of SW.
- SW, 8, serial beat width in bits; PW/SW >= 2.
- MSB_FIRST, 1, 1 = most-significant beat sent first; 0 = least-significant beat first.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_L  input  1  synchronous reset, active-low.
- in_put  input  1  upstream asserts: in_payload is valid.
- in_free  output  1  block can accept a word this cycle.
- in_payload  input  PW  parallel word.
- out_put  output  1  out_data holds a valid beat.
- out_free  input  1  downstream accepts the beat this cycle.
- out_data  output  SW  current beat.
- out_last  output  1  current beat is the final beat of the word.
- flush  input  1  synchronous abort of the word in flight.
- beat_idx  output  $clog2(PW/SW)  index of the current beat (0 = first sent).

Behaviour:
- Definitions:
  - BEATS = PW/SW.
  - Upstream transfer: cycle with in_put && in_free.
  - Beat transfer: cycle with out_put && out_free.
- Reset (reset_L low at posedge):
  - state = IDLE; shift register = 0; beat_idx = 0; out_put = 0; out_data = 0; out_last = 0.
  - in_free is forced to 0 while reset_L is low.
- State IDLE:
  - in_free = 1; out_put = 0.
  - On upstream transfer: capture in_payload; beat_idx <= 0; go to SEND.
- State SEND:
  - out_put = 1.
  - out_data is registered: the first beat appears the cycle after capture (latency 1).
  - out_data and beat_idx hold unchanged while out_free = 0. No beat is ever dropped or repeated.
  - On a beat transfer with beat_idx < BEATS-1: advance to the next beat; beat_idx increments.
  - out_last = 1 exactly when beat_idx == BEATS-1.
- Beat order:
  - MSB_FIRST = 1: beat k = payload[PW-1-k*SW -: SW].
  - MSB_FIRST = 0: beat k = payload[k*SW +: SW].
- Last beat and back-to-back:
  - in_free = out_last && out_free (combinational path from out_free).
  - Last beat transferred with in_put = 1: capture the new word and stay in SEND with beat_idx = 0. The next cycle shows the new word's first beat, with no bubble.
  - Last beat transferred with in_put = 0: go to IDLE; out_put = 0 the next cycle.
  - In SEND with beat_idx < BEATS-1: in_free = 0.
- flush (sampled at posedge; lower priority than reset only):
  - Return to IDLE, beat_idx <= 0, out_put <= 0, regardless of state or out_free.
  - While flush = 1, in_free = 0, so no word is captured that cycle.
  - A beat transferring in the flush cycle counts as delivered; the remaining beats are discarded.
- Reset mid-word: same as flush. The word is lost; no partial beats appear after reset.
- Stall tolerance: out_free may toggle arbitrarily. Only the total number of beat transfers per word (BEATS) and their order are guaranteed.
- Elaboration: if PW % SW != 0 or BEATS < 2, raise an error.

Test Plan:
- Defaults, in_payload = 32'h11223344, in_put pulsed 1 cycle, out_free = 1 -> out_put high 4 cycles; out_data = 11, 22, 33, 44; out_last only on 44; then IDLE with in_free = 1.
- MSB_FIRST = 0, same word -> out_data = 44, 33, 22, 11; beat_idx = 0..3.
- Stall: out_free = 0 for 2 cycles while beat 22 is shown -> out_data = 22 and beat_idx = 1 held for 3 cycles total; sequence completes 33, 44 with no duplicates.
- Back-to-back: in_put held high with 32'hAABBCCDD presented during the last beat (44) and out_free = 1 -> in_free = 1 that cycle; the next cycle out_data = AA; 8 beats delivered in 8 consecutive cycles.
- flush asserted while beat 22 is shown with out_free = 0 -> next cycle out_put = 0 and in_free = 1; beats 33 and 44 are never emitted; a subsequent word 32'h55667788 transfers normally.
- reset_L low for 1 cycle while beat 33 is shown -> in_free = 0 during reset; next cycle out_put = 0, out_data = 0, beat_idx = 0; then normal operation.

Source files
------------

// File: rtl/handshake_serializer.sv
// handshake_serializer: takes one PW-bit word over an upstream Put/Free
// handshake and sends it as PW/SW beats of SW bits over a downstream
// Put/Free handshake. Supports selectable beat order, per-beat stalls,
// back-to-back words without a bubble, and a synchronous flush.
module handshake_serializer #(
    parameter int PW        = 32,
    parameter int SW        = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      in_put,
    output logic                      in_free,
    input  logic [PW-1:0]             in_payload,
    output logic                      out_put,
    input  logic                      out_free,
    output logic [SW-1:0]             out_data,
    output logic                      out_last,
    input  logic                      flush,
    output logic [$clog2(PW/SW)-1:0]  beat_idx
);
    localparam int BEATS = PW / SW;
    localparam int IW    = $clog2(BEATS);
    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

    generate
        if (((PW % SW) != 0) || (BEATS < 2)) begin : g_bad_params
            $error("handshake_serializer: PW must be a multiple of SW and PW/SW must be >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   shreg, shreg_nxt;
    logic [IW-1:0]   idx_nxt;

    // The beat on the wire always sits at the outgoing end of the shift
    // register, so out_data comes straight from a flop.
    assign out_data = MSB_FIRST ? shreg[PW-1 -: SW] : shreg[SW-1:0];
    assign out_put  = (state == SEND);
    assign out_last = (state == SEND) && (beat_idx == LAST_IDX);

    // Next-state, shift-register and upstream-ready decode.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = beat_idx;
        in_free   = 1'b0;
        case (state)
            IDLE: begin
                in_free = reset_L && !flush;
                if (in_put && in_free) begin
                    shreg_nxt = in_payload;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                // Ready upstream only while the final beat is leaving, so a
                // new word can replace it with no idle cycle in between.
                in_free = reset_L && !flush && out_last && out_free;
                if (out_free) begin
                    if (beat_idx != LAST_IDX) begin
                        if (MSB_FIRST)
                            shreg_nxt = {shreg[PW-SW-1:0], {SW{1'b0}}};
                        else
                            shreg_nxt = {{SW{1'b0}}, shreg[PW-1:SW]};
                        idx_nxt = beat_idx + IW'(1);
                    end else if (in_put && in_free) begin
                        shreg_nxt = in_payload;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
        // Flush abandons whatever is in flight; the beat transferring this
        // cycle has already been seen downstream, the rest are dropped.
        if (flush) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end
    end

    // State, shift register and beat index registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state    <= IDLE;
            shreg    <= '0;
            beat_idx <= '0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            beat_idx <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_handshake_serializer.sv
// tb_handshake_serializer: directed bench for handshake_serializer with an
// MSB-first and an LSB-first instance driven by the same stimulus. Expected
// beats are queued when a word is accepted and compared as beats transfer.
module tb_handshake_serializer;
    localparam int PW    = 32;
    localparam int SW    = 8;
    localparam int BEATS = PW / SW;
    localparam int IW    = $clog2(BEATS);

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    logic in_put = 1'b0;
    logic out_free = 1'b0;
    logic flush = 1'b0;
    logic [PW-1:0] in_payload = '0;

    logic in_free_m, out_put_m, out_last_m;
    logic [SW-1:0] out_data_m;
    logic [IW-1:0] beat_idx_m;
    logic in_free_l, out_put_l, out_last_l;
    logic [SW-1:0] out_data_l;
    logic [IW-1:0] beat_idx_l;

    typedef struct {
        logic [SW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    beat_t q_m[$];
    beat_t q_l[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    handshake_serializer #(.PW(PW), .SW(SW), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset_L(reset_L), .in_put(in_put), .in_free(in_free_m),
        .in_payload(in_payload), .out_put(out_put_m), .out_free(out_free),
        .out_data(out_data_m), .out_last(out_last_m), .flush(flush),
        .beat_idx(beat_idx_m)
    );

    handshake_serializer #(.PW(PW), .SW(SW), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_L(reset_L), .in_put(in_put), .in_free(in_free_l),
        .in_payload(in_payload), .out_put(out_put_l), .out_free(out_free),
        .out_data(out_data_l), .out_last(out_last_l), .flush(flush),
        .beat_idx(beat_idx_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [PW-1:0] w);
        beat_t b;
        for (int k = 0; k < BEATS; k++) begin
            b.idx  = IW'(k);
            b.last = (k == BEATS - 1);
            b.data = w[PW-1-k*SW -: SW];
            q_m.push_back(b);
            b.data = w[k*SW +: SW];
            q_l.push_back(b);
        end
    endtask

    // One clock: score transfers at the falling edge, then step past the
    // rising edge so new stimulus is applied clear of it.
    task automatic cycle();
        beat_t e;
        @(negedge clk);
        if (out_put_m && out_free) begin
            if (q_m.size() == 0) begin
                chk("msb_spurious_beat", 32'(out_put_m), 32'h0);
            end else begin
                e = q_m.pop_front();
                chk("msb_data", 32'(out_data_m), 32'(e.data));
                chk("msb_idx",  32'(beat_idx_m), 32'(e.idx));
                chk("msb_last", 32'(out_last_m), 32'(e.last));
            end
        end
        if (out_put_l && out_free) begin
            if (q_l.size() == 0) begin
                chk("lsb_spurious_beat", 32'(out_put_l), 32'h0);
            end else begin
                e = q_l.pop_front();
                chk("lsb_data", 32'(out_data_l), 32'(e.data));
                chk("lsb_idx",  32'(beat_idx_l), 32'(e.idx));
                chk("lsb_last", 32'(out_last_l), 32'(e.last));
            end
        end
        if (flush || !reset_L) begin
            q_m.delete();
            q_l.delete();
        end
        if (in_put && in_free_m) push_word(in_payload);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_q_msb_empty"}, 32'(q_m.size()), 32'h0);
        chk({tag, "_q_lsb_empty"}, 32'(q_l.size()), 32'h0);
        chk({tag, "_out_put"}, 32'(out_put_m), 32'h0);
        chk({tag, "_in_free"}, 32'(in_free_m), 32'h1);
    endtask

    initial begin
        // Reset state.
        reset_L = 1'b0;
        cycle();
        cycle();
        chk("rst_in_free", 32'(in_free_m), 32'h0);
        chk("rst_out_put", 32'(out_put_m), 32'h0);
        chk("rst_out_data", 32'(out_data_m), 32'h0);
        chk("rst_beat_idx", 32'(beat_idx_m), 32'h0);
        chk("rst_out_last", 32'(out_last_m), 32'h0);
        reset_L = 1'b1;
        #1;
        chk("post_rst_in_free", 32'(in_free_m), 32'h1);

        // Single word, no back-pressure: four beats in four cycles.
        out_free = 1'b1;
        in_payload = 32'h11223344;
        in_put = 1'b1;
        cycle();
        in_put = 1'b0;
        chk("w1_first_msb", 32'(out_data_m), 32'h11);
        chk("w1_first_lsb", 32'(out_data_l), 32'h44);
        repeat (BEATS) cycle();
        check_idle("w1");

        // Stall on the second beat for two cycles.
        in_put = 1'b1;
        cycle();
        in_put = 1'b0;
        cycle();
        out_free = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("stall_msb_data", 32'(out_data_m), 32'h22);
            chk("stall_lsb_data", 32'(out_data_l), 32'h33);
            chk("stall_idx", 32'(beat_idx_m), 32'h1);
        end
        out_free = 1'b1;
        repeat (3) cycle();
        check_idle("stall");

        // Back-to-back words with no bubble.
        in_put = 1'b1;
        cycle();
        in_put = 1'b0;
        repeat (3) cycle();
        chk("b2b_last_shown", 32'(out_last_m), 32'h1);
        in_payload = 32'hAABBCCDD;
        in_put = 1'b1;
        #1;
        chk("b2b_in_free", 32'(in_free_m), 32'h1);
        cycle();
        in_put = 1'b0;
        chk("b2b_msb_first", 32'(out_data_m), 32'hAA);
        chk("b2b_lsb_first", 32'(out_data_l), 32'hDD);
        for (int i = 0; i < BEATS; i++) begin
            chk("b2b_no_bubble", 32'(out_put_m), 32'h1);
            cycle();
        end
        check_idle("b2b");

        // Flush while the second beat is stalled.
        in_payload = 32'h11223344;
        in_put = 1'b1;
        cycle();
        in_put = 1'b0;
        cycle();
        out_free = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_in_free", 32'(in_free_m), 32'h0);
        cycle();
        flush = 1'b0;
        #1;
        chk("flush_out_put", 32'(out_put_m), 32'h0);
        chk("flush_in_free_after", 32'(in_free_m), 32'h1);
        chk("flush_idx", 32'(beat_idx_m), 32'h0);
        out_free = 1'b1;
        repeat (2) cycle();
        in_payload = 32'h55667788;
        in_put = 1'b1;
        cycle();
        in_put = 1'b0;
        chk("post_flush_first", 32'(out_data_m), 32'h55);
        repeat (BEATS) cycle();
        check_idle("post_flush");

        // Reset in the middle of a word.
        in_payload = 32'h11223344;
        in_put = 1'b1;
        cycle();
        in_put = 1'b0;
        repeat (2) cycle();
        chk("mid_rst_shown", 32'(out_data_m), 32'h33);
        reset_L = 1'b0;
        #1;
        chk("mid_rst_in_free", 32'(in_free_m), 32'h0);
        cycle();
        reset_L = 1'b1;
        chk("mid_rst_out_put", 32'(out_put_m), 32'h0);
        chk("mid_rst_out_data", 32'(out_data_m), 32'h0);
        chk("mid_rst_beat_idx", 32'(beat_idx_m), 32'h0);
        chk("mid_rst_out_last", 32'(out_last_m), 32'h0);
        repeat (2) cycle();
        in_payload = 32'h55667788;
        in_put = 1'b1;
        cycle();
        in_put = 1'b0;
        repeat (BEATS) cycle();
        check_idle("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
